// File: rtl/guess_game_ctrl.sv
// Guess-the-number game sequencer: draws a secret from the LFSR by rejection
// sampling, scores guesses, counts attempts, and latches a win/loss result
// until the next start.
module guess_game_ctrl #(
  parameter int WIDTH     = 6,
  parameter int MAX_VALUE = 50,
  parameter int MAX_TRIES = 7,
  localparam int AW       = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] rnd,
  input  logic [WIDTH-1:0] guess,
  input  logic             guess_valid,
  output logic             busy,
  output logic             ready,
  output logic [1:0]       hint,
  output logic             hint_valid,
  output logic [AW-1:0]    attempts,
  output logic             won,
  output logic             lost,
  output logic [WIDTH-1:0] secret
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VALUE);
  localparam logic [AW-1:0]    TRIES = AW'(MAX_TRIES);

  localparam logic [1:0] HINT_OOR  = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_OK   = 2'b11;

  typedef enum logic [2:0] {IDLE, DRAW, PLAY, WON, LOST} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] secret_q, secret_nx;
  logic [1:0]       hint_nx;
  logic             hv_nx;
  logic [AW-1:0]    att_nx;
  logic [AW-1:0]    att_inc;

  // Saturating increment; in practice PLAY never sees attempts at the limit.
  assign att_inc = (attempts == TRIES) ? attempts : attempts + AW'(1);

  // State, datapath and registered status outputs (all decoded from next state).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      secret_q   <= '0;
      hint       <= HINT_OOR;
      hint_valid <= 1'b0;
      attempts   <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      won        <= 1'b0;
      lost       <= 1'b0;
      secret     <= '0;
    end else begin
      state      <= state_nx;
      secret_q   <= secret_nx;
      hint       <= hint_nx;
      hint_valid <= hv_nx;
      attempts   <= att_nx;
      busy       <= (state_nx == DRAW);
      ready      <= (state_nx == PLAY);
      won        <= (state_nx == WON);
      lost       <= (state_nx == LOST);
      secret     <= (state_nx == WON || state_nx == LOST) ? secret_nx : '0;
    end
  end

  // Next-state and datapath updates; start beats guess_valid everywhere but DRAW.
  always_comb begin
    state_nx  = state;
    secret_nx = secret_q;
    hint_nx   = hint;
    hv_nx     = 1'b0;
    att_nx    = attempts;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = DRAW;
          att_nx   = '0;
          hint_nx  = HINT_OOR;
        end
      end
      DRAW: begin
        if (rnd <= MAXV) begin
          secret_nx = rnd;
          state_nx  = PLAY;
        end
      end
      PLAY: begin
        if (start) begin
          state_nx = DRAW;
          att_nx   = '0;
          hint_nx  = HINT_OOR;
        end else if (guess_valid) begin
          hv_nx = 1'b1;
          if (guess > MAXV) begin
            hint_nx = HINT_OOR;
          end else begin
            att_nx = att_inc;
            if (guess == secret_q) begin
              hint_nx  = HINT_OK;
              state_nx = WON;
            end else begin
              hint_nx = (guess < secret_q) ? HINT_LOW : HINT_HIGH;
              if (att_inc == TRIES) state_nx = LOST;
            end
          end
        end
      end
      WON, LOST: begin
        if (start) begin
          state_nx = DRAW;
          att_nx   = '0;
          hint_nx  = HINT_OOR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with default parameters (6/50/7).
module tb_guess_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] rnd;
  logic [5:0] guess;
  logic       guess_valid;
  logic       busy, ready, hint_valid, won, lost;
  logic [1:0] hint;
  logic [2:0] attempts;
  logic [5:0] secret;

  int tests = 0;
  int fails = 0;

  guess_game_ctrl dut (.*);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},     busy, 0);
    check({tag, ".ready"},    ready, 0);
    check({tag, ".hint"},     hint, 0);
    check({tag, ".hv"},       hint_valid, 0);
    check({tag, ".attempts"}, attempts, 0);
    check({tag, ".won"},      won, 0);
    check({tag, ".lost"},     lost, 0);
    check({tag, ".secret"},   secret, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_guess(input logic [5:0] g);
    guess       = g;
    guess_valid = 1'b1;
    tick();
    guess_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; rnd = 6'd62; guess = 0; guess_valid = 0;
    #2;
    check_all_zero("reset");
    tick(); tick();
    reset = 1'b0;
    tick();
    // IDLE ignores guesses
    do_guess(6'd3);
    check("idle.hv", hint_valid, 0);
    check("idle.ready", ready, 0);

    // Draw rejection: 62, 61, 59 refused, 27 accepted
    do_start();
    check("drawA.busy0", busy, 1);
    check("drawA.att0", attempts, 0);
    rnd = 6'd62; tick(); check("drawA.busy62", busy, 1);
    rnd = 6'd61; tick(); check("drawA.busy61", busy, 1);
    rnd = 6'd59; tick(); check("drawA.busy59", busy, 1);
    rnd = 6'd27; tick();
    check("drawA.busy_done", busy, 0);
    check("drawA.ready", ready, 1);
    check("playA.secret_hidden", secret, 0);
    rnd = 6'd62;

    do_guess(6'd10);
    check("g10.hint", hint, 2'b01); check("g10.hv", hint_valid, 1); check("g10.att", attempts, 1);
    tick();
    check("g10.hv_drop", hint_valid, 0); check("g10.hint_hold", hint, 2'b01);
    do_guess(6'd40);
    check("g40.hint", hint, 2'b10); check("g40.hv", hint_valid, 1); check("g40.att", attempts, 2);
    do_guess(6'd27);
    check("g27.hint", hint, 2'b11); check("g27.hv", hint_valid, 1); check("g27.att", attempts, 3);
    check("g27.won", won, 1); check("g27.secret", secret, 27); check("g27.ready", ready, 0);
    do_guess(6'd5);
    check("wonA.hv_ignored", hint_valid, 0); check("wonA.att", attempts, 3);
    check("wonA.won_hold", won, 1);

    // Loss: secret 5, seven guesses of 6
    do_start();
    check("drawB.won_clr", won, 0); check("drawB.att", attempts, 0); check("drawB.hint", hint, 0);
    rnd = 6'd5; tick(); rnd = 6'd62;
    check("drawB.ready", ready, 1);
    for (int i = 1; i <= 7; i++) begin
      do_guess(6'd6);
      check("lossB.hint", hint, 2'b10);
      check("lossB.hv", hint_valid, 1);
      check("lossB.att", attempts, i);
      check("lossB.lost", lost, (i == 7) ? 1 : 0);
    end
    check("lossB.secret", secret, 5);
    do_guess(6'd5);
    check("lossB.8th_hv", hint_valid, 0); check("lossB.8th_att", attempts, 7);
    check("lossB.8th_won", won, 0); check("lossB.8th_lost", lost, 1);

    // Out-of-range guess, then a win on the final try
    do_start();
    check("drawC.lost_clr", lost, 0); check("drawC.secret", secret, 0); check("drawC.att", attempts, 0);
    rnd = 6'd20; tick(); rnd = 6'd62;
    do_guess(6'd55);
    check("g55.hint", hint, 2'b00); check("g55.hv", hint_valid, 1); check("g55.att", attempts, 0);
    do_guess(6'd51);
    check("g51.hint", hint, 2'b00); check("g51.att", attempts, 0);
    do_guess(6'd50);
    check("g50.hint", hint, 2'b10); check("g50.att", attempts, 1);
    for (int i = 2; i <= 6; i++) begin
      do_guess(6'(i));
      check("missC.hint", hint, 2'b01);
      check("missC.att", attempts, i);
    end
    do_guess(6'd20);
    check("finalC.hint", hint, 2'b11); check("finalC.won", won, 1);
    check("finalC.lost", lost, 0); check("finalC.att", attempts, 7); check("finalC.secret", secret, 20);

    // start beats a simultaneous correct guess
    do_start();
    rnd = 6'd33; tick(); rnd = 6'd62;
    do_guess(6'd1); do_guess(6'd1);
    check("D.att2", attempts, 2);
    start = 1'b1; guess = 6'd33; guess_valid = 1'b1;
    tick();
    start = 1'b0; guess_valid = 1'b0;
    check("D.hv", hint_valid, 0); check("D.busy", busy, 1);
    check("D.att", attempts, 0); check("D.won", won, 0);
    // start during DRAW does nothing; rejection continues
    start = 1'b1; tick(); start = 1'b0;
    check("D.draw_start_busy", busy, 1);
    rnd = 6'd12; tick(); rnd = 6'd62;
    check("D.ready", ready, 1);

    // Asynchronous reset mid-PLAY after three guesses
    do_guess(6'd1); do_guess(6'd2); do_guess(6'd3);
    check("E.att3", attempts, 3);
    #2 reset = 1'b1;
    #1;
    check_all_zero("E.async");
    tick();
    reset = 1'b0;
    tick();
    do_guess(6'd12);
    check("E.idle_hv", hint_valid, 0); check("E.idle_ready", ready, 0);
    check("E.idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
